// File: rtl/window_gen_7x7.sv
// Streaming 7x7 sliding-window generator: six line buffers feed a 7x7 register
// window whose packed contents drive the downstream 7x7 filter.
module window_gen_7x7 #(
   parameter int PIX_BIT    = 8,
   parameter int MASK_WIDTH = 7,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COL_BIT    = 10,
   parameter int ROW_BIT    = 9
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [PIX_BIT-1:0]                      pix_in,
   input  logic                                    pix_valid,
   input  logic                                    sof,
   output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] p,
   output logic                                    window_valid,
   output logic [COL_BIT-1:0]                      col,
   output logic [ROW_BIT-1:0]                      row
);

   localparam int N       = MASK_WIDTH;
   localparam int LB_ROWS = N - 1;

   localparam logic [COL_BIT-1:0] COL_LAST  = COL_BIT'(IMG_WIDTH - 1);
   localparam logic [ROW_BIT-1:0] ROW_LAST  = ROW_BIT'(IMG_HEIGHT - 1);
   localparam logic [COL_BIT-1:0] COL_FIRST = COL_BIT'(N - 1);
   localparam logic [ROW_BIT-1:0] ROW_FIRST = ROW_BIT'(N - 1);

   logic                 accept;
   logic [COL_BIT-1:0]   cur_col;
   logic [ROW_BIT-1:0]   cur_row;
   logic [PIX_BIT-1:0]   lb      [LB_ROWS][IMG_WIDTH];
   logic [PIX_BIT-1:0]   col_vec [N];
   logic [PIX_BIT-1:0]   win     [N][N];

   // A start-of-frame pixel is always position (0,0), whatever the counters say.
   assign accept  = pix_valid;
   assign cur_col = sof ? '0 : col;
   assign cur_row = sof ? '0 : row;

   // Column entering the window: oldest line buffer on top, live pixel at the bottom.
   always_comb begin
      col_vec = '{default: '0};
      for (int r = 0; r < LB_ROWS; r++) begin
         col_vec[r] = lb[LB_ROWS-1-r][cur_col];
      end
      col_vec[N-1] = pix_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end
   end

   // Buffers are never cleared; stale lines stay hidden until six fresh rows exist.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb[0][cur_col] <= pix_in;
         for (int k = 1; k < LB_ROWS; k++) begin
            lb[k][cur_col] <= lb[k-1][cur_col];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               win[r][c] <= '0;
            end
         end
         window_valid <= 1'b0;
      end else begin
         if (accept) begin
            for (int r = 0; r < N; r++) begin
               for (int c = 0; c < N-1; c++) begin
                  win[r][c] <= win[r][c+1];
               end
               win[r][N-1] <= col_vec[r];
            end
         end
         window_valid <= accept && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
      end
   end

   always_comb begin
      p = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            p[PIX_BIT*(r*N+c) +: PIX_BIT] = win[r][c];
         end
      end
   end

endmodule

// File: tb/tb_window_gen_7x7.sv
// Self-checking bench for window_gen_7x7 on a 16x12 image, using a frame-array
// reference model that rebuilds each expected window from absolute pixel positions.
module tb_window_gen_7x7;

   localparam int W  = 16;
   localparam int H  = 12;
   localparam int PB = 8;
   localparam int CB = 4;
   localparam int RB = 4;
   localparam int PW = PB*49;

   logic          clk = 1'b0;
   logic          reset;
   logic [PB-1:0] pix_in;
   logic          pix_valid;
   logic          sof;
   logic [PW-1:0] p;
   logic          window_valid;
   logic [CB-1:0] col;
   logic [RB-1:0] row;

   window_gen_7x7 #(
      .PIX_BIT(PB), .MASK_WIDTH(7), .IMG_WIDTH(W), .IMG_HEIGHT(H),
      .COL_BIT(CB), .ROW_BIT(RB)
   ) dut (
      .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
      .p(p), .window_valid(window_valid), .col(col), .row(row)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [PB-1:0] img [H][W];
   int            mr, mc;
   logic          exp_wv;
   logic [PW-1:0] exp_p;
   logic [PW-1:0] last_p;
   logic          have_last;
   int            since_sof;
   int            win_seen;
   int            first_win_at;
   logic [PW-1:0] first_p;

   typedef struct {
      logic [PB-1:0] pix;
      logic          valid;
      logic          s;
      logic [CB-1:0] exp_col;
      logic [RB-1:0] exp_row;
      logic          exp_wv;
   } vec_t;

   vec_t vecs [6];

   task automatic checkVal(input string name, input longint act, input longint expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic checkP(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [PB-1:0] pat(input int r, input int c);
      return PB'(16*r + c);
   endfunction

   // Reference: remember every accepted pixel at its frame position; a window is
   // simply the 7x7 block of the frame ending at the triggering pixel.
   task automatic modelStep(input logic [PB-1:0] pix, input logic valid, input logic s);
      exp_wv = 1'b0;
      if (valid) begin
         if (s) begin
            mr = 0;
            mc = 0;
            since_sof = 0;
         end
         since_sof++;
         img[mr][mc] = pix;
         exp_wv = (mr >= 6) && (mc >= 6);
         if (exp_wv) begin
            for (int i = 0; i < 7; i++)
               for (int j = 0; j < 7; j++)
                  exp_p[PB*(i*7+j) +: PB] = img[mr-6+i][mc-6+j];
            last_p    = exp_p;
            have_last = 1'b1;
         end else begin
            have_last = 1'b0;
         end
         mc++;
         if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end
      end
   endtask

   task automatic checkOutput(input logic valid);
      checkVal("col", col, mc);
      checkVal("row", row, mr);
      checkVal("window_valid", window_valid, exp_wv);
      if (exp_wv) checkP("window", p, exp_p);
      else if (!valid && have_last) checkP("held p", p, last_p);
      if (window_valid) begin
         win_seen++;
         if (first_win_at < 0) begin
            first_win_at = since_sof;
            first_p      = p;
         end
      end
   endtask

   task automatic applyStimulus(input logic [PB-1:0] pix, input logic valid, input logic s);
      pix_in    = pix;
      pix_valid = valid;
      sof       = s;
      @(posedge clk);
      #1;
      modelStep(pix, valid, s);
      checkOutput(valid);
   endtask

   task automatic modelReset();
      mr = 0; mc = 0;
      last_p = '0; have_last = 1'b1;
      since_sof = 0;
      first_win_at = -1;
      win_seen = 0;
   endtask

   task automatic startTest();
      win_seen = 0;
      first_win_at = -1;
   endtask

   task automatic runFrame(input int gap_every, input int gap_len, input bit with_sof);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            applyStimulus(pat(r, c), 1'b1, with_sof && r == 0 && c == 0);
            if (gap_every > 0 && ((r*W + c + 1) % gap_every) == 0)
               repeat (gap_len) applyStimulus('0, 1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      vecs[0] = '{8'h11, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0};
      vecs[1] = '{8'h22, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0};
      vecs[2] = '{8'h33, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0};
      vecs[3] = '{8'h44, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0};
      vecs[4] = '{8'h55, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0};
      vecs[5] = '{8'h66, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0};

      reset = 1'b1; pix_in = '0; pix_valid = 1'b0; sof = 1'b0;
      modelReset();
      #21;
      checkVal("reset col", col, 0);
      checkVal("reset row", row, 0);
      checkVal("reset window_valid", window_valid, 0);
      checkP("reset p", p, '0);
      reset = 1'b0;
      applyStimulus('0, 1'b0, 1'b0);

      // Table of short sequences: sof restart, idle cycles, sof ignored when idle.
      for (int i = 0; i < 6; i++) begin
         pix_in = vecs[i].pix; pix_valid = vecs[i].valid; sof = vecs[i].s;
         @(posedge clk);
         #1;
         modelStep(vecs[i].pix, vecs[i].valid, vecs[i].s);
         checkVal("vec col", col, vecs[i].exp_col);
         checkVal("vec row", row, vecs[i].exp_row);
         checkVal("vec window_valid", window_valid, vecs[i].exp_wv);
      end

      // Continuous frame
      startTest();
      runFrame(0, 0, 1'b1);
      checkVal("frame windows", win_seen, 60);
      checkVal("frame first window accepts", first_win_at, 103);
      checkVal("first elem0", first_p[0*PB +: PB], 0);
      checkVal("first elem6", first_p[6*PB +: PB], 6);
      checkVal("first elem42", first_p[42*PB +: PB], 96);
      checkVal("first elem48", first_p[48*PB +: PB], 102);

      // Same frame with gaps
      startTest();
      runFrame(5, 3, 1'b1);
      checkVal("gap windows", win_seen, 60);

      // Back-to-back frames
      startTest();
      runFrame(0, 0, 1'b1);
      first_win_at = -1;
      runFrame(0, 0, 1'b1);
      checkVal("two frame windows", win_seen, 120);
      checkVal("frame2 first window accepts", first_win_at, 103);
      checkVal("frame2 elem0", first_p[0*PB +: PB], 0);

      // sof mid-frame at (8,3)
      startTest();
      for (int idx = 0; idx < 8*W + 3; idx++)
         applyStimulus(pat(idx / W, idx % W), 1'b1, idx == 0);
      applyStimulus(pat(8, 3), 1'b1, 1'b1);
      checkVal("sof restart col", col, 1);
      checkVal("sof restart row", row, 0);
      first_win_at = -1;
      win_seen = 0;
      for (int idx = 1; idx < W*H; idx++)
         applyStimulus(pat(idx / W, idx % W), 1'b1, 1'b0);
      checkVal("sof restart first window accepts", first_win_at, 103);
      checkVal("sof restart windows", win_seen, 60);

      // Asynchronous reset mid row 7, between edges
      startTest();
      for (int idx = 0; idx < 7*W + 8; idx++)
         applyStimulus(pat(idx / W, idx % W), 1'b1, idx == 0);
      pix_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkVal("async reset col", col, 0);
      checkVal("async reset row", row, 0);
      checkVal("async reset window_valid", window_valid, 0);
      checkP("async reset p", p, '0);
      #1 reset = 1'b0;
      modelReset();
      runFrame(0, 0, 1'b0);
      checkVal("post reset first window accepts", first_win_at, 103);
      checkVal("post reset windows", win_seen, 60);

      // Pixel 255 at (6,6), then wrap into row 7
      startTest();
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            applyStimulus((r == 6 && c == 6) ? 8'd255 : pat(r, c), 1'b1, r == 0 && c == 0);
            if (r == 6 && c == 6) checkVal("bright elem48", p[48*PB +: PB], 255);
            if (r == 7 && c < 6) checkVal("wrap no window", window_valid, 0);
            if (r == 7 && c == 6) checkVal("wrap elem0", p[0*PB +: PB], 16);
         end
      end

      // Random pixels, random gaps, occasional sof restarts
      startTest();
      applyStimulus(PB'($urandom), 1'b1, 1'b1);
      for (int i = 0; i < 900; i++)
         applyStimulus(PB'($urandom), ($urandom % 4) != 0, ($urandom % 300) == 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/window_gen_7x7.md
# window_gen_7x7

Streaming sliding-window generator that sits directly upstream of the 7x7 filter function. It accepts raster-order pixels one per clock and keeps six line buffers plus a 7x7 register window. For every pixel position where a full 7x7 neighbourhood exists, it presents that neighbourhood on a packed bus matching the filter's `p` input. Its `window_valid` output drives the filter's `enable`.

## Interface
Parameters:
- `PIX_BIT`, 8, pixel width in bits.
- `MASK_WIDTH`, 7, window side. Fixed at 7; other values are unsupported.
- `IMG_WIDTH`, 640, pixels per line. Also the line-buffer depth. Minimum 7.
- `IMG_HEIGHT`, 480, lines per frame. Minimum 7.
- `COL_BIT`, 10, column counter width. Must satisfy 2^`COL_BIT` >= `IMG_WIDTH`.
- `ROW_BIT`, 9, row counter width. Must satisfy 2^`ROW_BIT` >= `IMG_HEIGHT`.

Ports (clock and reset first):
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `pix_in`, in, `PIX_BIT`: input pixel, unsigned.
- `pix_valid`, in, 1: `pix_in` is accepted on any edge where this is high. There is no backpressure.
- `sof`, in, 1: start of frame. Sampled only when `pix_valid` is high; marks the current pixel as position (row 0, col 0).
- `p`, out, `PIX_BIT`*49: packed window. Element i = r*7+c sits at bits [`PIX_BIT`*(i+1)-1 : `PIX_BIT`*i].
  - r=0 is the oldest (top) row; r=6 is the current row.
  - c=0 is the oldest (left) column; c=6 is the newest.
- `window_valid`, out, 1: `p` holds a complete, in-frame window.
- `col`, out, `COL_BIT`: column of the next expected pixel.
- `row`, out, `ROW_BIT`: row of the next expected pixel.

## Operation
- Counters `col` and `row`:
  - Both advance only on accepted pixels.
  - `col` wraps from `IMG_WIDTH`-1 to 0 and increments `row`.
  - `row` wraps from `IMG_HEIGHT`-1 to 0.
  - An accepted pixel with `sof`=1 is treated as position (0,0); the counters become (0,1) afterwards. This takes priority over normal counting.
- Line buffers `LB0`..`LB5`:
  - Each is an `IMG_WIDTH`-deep RAM, addressed by the accepted pixel's column. Synchronous read, read-before-write.
  - On accept at column x: `LB0[x]` <= `pix_in`, and `LBk[x]` <= old `LB(k-1)[x]` for k=1..5.
  - The column vector fed into the window is {`LB5[x]`, ..., `LB0[x]`, `pix_in`}, ordered as rows r=0..6.
  - Only the read-before-write ordering is mandated; the implementation chooses register vs. RAM.
- Window:
  - On accept, every row shifts left by one column (c <= c+1), and the new column vector loads into c=6.
  - The window holds when no pixel is accepted.
- Validity:
  - `window_valid` <= 1 on the edge that accepts a pixel at (row>=6, col>=6) in frame coordinates.
  - Otherwise `window_valid` <= 0. This includes idle cycles, which produce one-cycle pulses per accepted window.
  - Windows that straddle a line wrap (col<6) are never flagged.
  - Windows per frame: (`IMG_WIDTH`-6)*(`IMG_HEIGHT`-6).
- Centre pixel of a flagged window = frame pixel (row-3, col-3) of the triggering pixel. Downstream sizing is the consumer's concern.
- Reset:
  - `col`, `row`, `window_valid` and the window registers clear to 0.
  - Line-buffer contents are not cleared. They cannot leak out, because validity needs 6 fresh rows.
  - Reset mid-frame aborts the frame. The next accepted pixel is (0,0) whether or not `sof` is asserted.
- `sof` arriving mid-frame restarts counting immediately. No window is flagged until row>=6 of the new frame.

## Timing
- Latency: `p` and `window_valid` update on the same edge that accepts the triggering pixel, i.e. they are visible one cycle after `pix_in` is presented.
- Line-buffer read data for column x must be available in that same accept edge. Either use an asynchronous or distributed read, or pre-fetch column x+1 one accept ahead. The externally observed latency stays 1 cycle either way.
- Throughput: one window per clock when `pix_valid` is held high. No bubbles at line wrap.
- `pix_valid` gaps of any length: window, counters and buffers hold; `window_valid`=0 during the gap.
- Output values after reset, before the first accept: all zeros.

## Test plan
Use `IMG_WIDTH`=16, `IMG_HEIGHT`=12, and stimulus pixel(r,c) = (16r+c) mod 256.
- Continuous frame with `sof` on the first pixel → first `window_valid` one cycle after accepting pixel index 102 (row 6, col 6). At that point p element 0 = 0, element 6 = 6, element 42 = 96, element 48 = 102. The frame yields exactly 60 pulses, none at col<6.
- Same frame with `pix_valid` low for 3 cycles after every 5th pixel → identical sequence of 60 `p` values. `window_valid` is low during every gap, and `p` is held constant during gaps.
- Two back-to-back frames with `sof` on each first pixel → 120 windows. The first window of frame 2 has element 0 = 0 (new-frame data) and appears 103 accepts after the frame-2 `sof`.
- `sof` asserted at frame pixel (8,3) → counters read (0,1) after that accept. No `window_valid` until 103 accepts after that `sof`.
- `reset` pulsed asynchronously mid-row 7 (between edges) → `window_valid`, `col`, `row` and `p` drop to 0 immediately. The restarted frame produces its first window after 103 accepts, with correct values.
- Pixel 255 at (6,6) followed by wrap to (7,0) → no `window_valid` for cols 0..5 of row 7. Window at (7,6) has element 0 = pixel(1,0) = 16.
